// File: rtl/crumb_seq.sv
// crumb_seq: load / run / dump sequencer for a serial chain of crumb cells.
// It shifts a pattern into the chain, pulses the cells through num_gens
// generations, then streams the chain contents out while recirculating them.
module crumb_seq #(
    parameter int CHAIN_LEN  = 64,
    parameter int RUN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] num_gens,
    input  logic       load_valid,
    input  logic       load_bit,
    output logic       load_ready,
    output logic       cell_en,
    output logic       cell_run,
    output logic       cell_display,
    output logic       cell_shift_in,
    input  logic       chain_tail,
    output logic       disp_bit,
    output logic       disp_valid,
    input  logic       disp_ready,
    output logic       disp_last,
    output logic       busy,
    output logic       done
);

    localparam int             BW       = $clog2(CHAIN_LEN + 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(CHAIN_LEN - 1);
    localparam logic [3:0]     LAST_RUN = 4'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]    run_cnt_q, run_cnt_d;
    logic [7:0]    gen_cnt_q, gen_cnt_d;

    // State and counter registers; reset lands in IDLE so every output decodes to 0 at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            run_cnt_q <= '0;
            gen_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            run_cnt_q <= run_cnt_d;
            gen_cnt_q <= gen_cnt_d;
        end
    end

    // Next-state, counter updates and combinational output decode.
    always_comb begin
        // NOTE: every value written here gets a default first so no path infers a latch.
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        run_cnt_d     = run_cnt_q;
        gen_cnt_d     = gen_cnt_q;
        load_ready    = 1'b0;
        cell_en       = 1'b0;
        cell_run      = 1'b0;
        cell_display  = 1'b0;
        cell_shift_in = 1'b0;
        disp_bit      = 1'b0;
        disp_valid    = 1'b0;
        disp_last     = 1'b0;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    bit_cnt_d = '0;
                    gen_cnt_d = num_gens;
                end
            end

            S_LOAD: begin
                load_ready    = 1'b1;
                cell_en       = load_valid;
                cell_shift_in = load_bit;
                if (load_valid) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        run_cnt_d = '0;
                        if (gen_cnt_q == 8'd0) begin
                            // Zero generations: skip straight to the dump.
                            state_d   = S_DUMP;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
            end

            S_RUN: begin
                cell_en  = 1'b1;
                cell_run = 1'b1;
                if (run_cnt_q == LAST_RUN) begin
                    // One generation finished.
                    run_cnt_d = '0;
                    gen_cnt_d = gen_cnt_q - 8'd1;
                    if (gen_cnt_q == 8'd1) begin
                        state_d   = S_DUMP;
                        bit_cnt_d = '0;
                    end
                end else begin
                    run_cnt_d = run_cnt_q + 4'd1;
                end
            end

            S_DUMP: begin
                // Tail bit goes out and back into the head, so the pattern survives the dump.
                disp_valid    = 1'b1;
                disp_bit      = chain_tail;
                cell_shift_in = chain_tail;
                cell_en       = disp_ready;
                disp_last     = (bit_cnt_q == LAST_BIT);
                if (disp_ready) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition, including a start seen in IDLE.
        if (abort) begin
            state_d = S_IDLE;
        end
    end

endmodule

// File: tb/tb_crumb_seq.sv
// Self-checking bench for crumb_seq (CHAIN_LEN=8, RUN_CYCLES=2).
// A simple shift-register stands in for the cell chain; a phase-level
// model predicts every output each cycle.
module tb_crumb_seq;

    localparam int CL = 8;
    localparam int RC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [7:0] num_gens;
    logic       load_valid, load_bit, load_ready;
    logic       cell_en, cell_run, cell_display, cell_shift_in;
    logic       chain_tail;
    logic       disp_bit, disp_valid, disp_ready, disp_last;
    logic       busy, done;

    crumb_seq #(.CHAIN_LEN(CL), .RUN_CYCLES(RC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_gens      (num_gens),
        .load_valid    (load_valid),
        .load_bit      (load_bit),
        .load_ready    (load_ready),
        .cell_en       (cell_en),
        .cell_run      (cell_run),
        .cell_display  (cell_display),
        .cell_shift_in (cell_shift_in),
        .chain_tail    (chain_tail),
        .disp_bit      (disp_bit),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_last     (disp_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Cell chain stand-in: shifts when enabled and not running; index CL-1 is the tail.
    logic [CL-1:0] chain = '0;
    always @(posedge clk) begin
        if (cell_en && !cell_run) chain <= {chain[CL-2:0], cell_shift_in};
    end
    assign chain_tail = chain[CL-1];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model state
    typedef enum int {P_IDLE, P_LOAD, P_RUN, P_DUMP, P_DONE} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_loaded, m_run_left, m_dumped, m_gens;
    bit     m_pat [CL];

    // Monitors (only incremented, read as differences by the stimulus)
    int         en_load_cnt = 0, run_mon = 0, acc_cnt = 0, done_cnt = 0;
    int         last_at = 0, last_cyc = 0, done_cyc = 0;
    logic [7:0] acc_vec = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {load_ready, cell_en, cell_run, cell_display, cell_shift_in,
                disp_bit, disp_valid, disp_last, busy, done};
    endfunction

    // Per-cycle compare against the model, monitor update, then model step.
    task automatic compare_and_step();
        logic [9:0] exp, mask;
        exp  = '0;
        mask = '1;
        if (!rst_n) begin
            m_phase = P_IDLE;
            check("outputs_in_reset", outs(), 10'd0);
        end else begin
            case (m_phase)
                P_LOAD: begin
                    exp[9] = 1'b1; exp[8] = load_valid; exp[5] = load_bit; exp[1] = 1'b1;
                end
                P_RUN: begin
                    exp[8] = 1'b1; exp[7] = 1'b1; exp[1] = 1'b1; mask[5] = 1'b0;
                end
                P_DUMP: begin
                    exp[8] = disp_ready;
                    exp[5] = m_pat[m_dumped];
                    exp[4] = m_pat[m_dumped];
                    exp[3] = 1'b1;
                    exp[2] = (m_dumped == CL - 1);
                    exp[1] = 1'b1;
                end
                P_DONE: begin
                    exp[1] = 1'b1; exp[0] = 1'b1;
                end
                default: exp = '0;
            endcase
            check("outputs", outs() & mask, exp & mask);

            if (cell_en && load_ready) en_load_cnt++;
            if (cell_run) run_mon++;
            if (disp_valid && disp_ready) begin
                acc_cnt++;
                acc_vec = {acc_vec[6:0], disp_bit};
                if (disp_last) begin
                    last_at  = acc_cnt;
                    last_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            if (abort) begin
                m_phase = P_IDLE;
            end else begin
                case (m_phase)
                    P_IDLE: if (start) begin
                        m_phase  = P_LOAD;
                        m_loaded = 0;
                        m_gens   = int'(num_gens);
                    end
                    P_LOAD: if (load_valid) begin
                        m_pat[m_loaded] = load_bit;
                        m_loaded++;
                        if (m_loaded == CL) begin
                            m_dumped   = 0;
                            m_run_left = m_gens * RC;
                            m_phase    = (m_gens == 0) ? P_DUMP : P_RUN;
                        end
                    end
                    P_RUN: begin
                        m_run_left--;
                        if (m_run_left == 0) m_phase = P_DUMP;
                    end
                    P_DUMP: if (disp_ready) begin
                        m_dumped++;
                        if (m_dumped == CL) m_phase = P_DONE;
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
        cyc++;
    endtask

    // One clock: compare at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_and_step();
        @(posedge clk);
        #1;
    endtask

    // Full start/load/run/dump sequence with selectable stall, abort and stray-start behaviour.
    task automatic do_seq(input logic [7:0] pat, input logic [7:0] ng, input int vmode,
                          input int rmode, input int abort_load_at, input int abort_dump_at,
                          input bit start_in_dump);
        int en_b, run_b, acc_b, done_b, guard, idx, acc, stall;
        bit aborted;
        aborted = 0;
        en_b = en_load_cnt; run_b = run_mon; acc_b = acc_cnt; done_b = done_cnt;

        start = 1'b1; num_gens = ng;
        tick();
        start = 1'b0; num_gens = 8'($urandom);
        check("busy_after_start", busy, 1);

        idx = 0; guard = 0;
        while (idx < CL && guard < 200 && !aborted) begin
            load_bit = pat[CL-1-idx];
            if (abort_load_at == idx) begin
                abort = 1'b1; load_valid = 1'b1;
                tick();
                abort = 1'b0; load_valid = 1'b0;
                aborted = 1;
                check("idle_after_load_abort", busy, 0);
            end else begin
                case (vmode)
                    0:       load_valid = 1'b1;
                    1:       load_valid = (guard % 2 == 1);
                    default: load_valid = 1'($urandom_range(0, 1));
                endcase
                tick();
                if (load_valid) idx++;
                guard++;
            end
        end
        load_valid = 1'b0; load_bit = 1'b0;

        if (!aborted) begin
            check("load_complete", idx, CL);
            guard = 0;
            while (!disp_valid && guard < 600) begin
                tick();
                guard++;
            end
            check("dump_reached", disp_valid, 1);
            check("run_cycles", run_mon - run_b, int'(ng) * RC);

            acc = 0; stall = 0; guard = 0;
            while (acc < CL && guard < 200 && !aborted) begin
                case (rmode)
                    0: disp_ready = 1'b1;
                    1: if (acc == 3 && stall < 5) begin
                           disp_ready = 1'b0; stall++;
                       end else disp_ready = 1'b1;
                    default: disp_ready = 1'($urandom_range(0, 1));
                endcase
                start = (start_in_dump && acc == 2);
                abort = (abort_dump_at == acc);
                tick();
                start = 1'b0;
                if (abort) begin
                    abort = 1'b0; aborted = 1;
                    check("idle_after_dump_abort", busy, 0);
                end else if (disp_ready) begin
                    acc++;
                end
                guard++;
            end
            disp_ready = 1'b0;

            if (!aborted) begin
                tick();
                check("idle_after_done", busy, 0);
                check("done_count", done_cnt - done_b, 1);
                check("load_pulses", en_load_cnt - en_b, CL);
                check("accepted_bits", acc_cnt - acc_b, CL);
                check("dump_order", acc_vec, pat);
                check("last_index", last_at - acc_b, CL);
                check("done_delay", done_cyc - last_cyc, 1);
                check("recirculated", chain, pat);
            end
        end
        if (aborted) check("no_done_on_abort", done_cnt - done_b, 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_gens = '0;
        load_valid = 1'b0; load_bit = 1'b0; disp_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_load_ready", load_ready, 0);
        check("reset_disp_valid", disp_valid, 0);

        // Blinker row, zero generations: dump equals load order.
        do_seq(8'b0000_0111, 8'd0, 0, 0, -1, -1, 1'b0);
        check("blinker_dump", acc_vec, 8'b0000_0111);

        // Three generations: six run cycles.
        r0 = run_mon;
        do_seq(8'b0000_0111, 8'd3, 0, 0, -1, -1, 1'b0);
        check("run_six_cycles", run_mon - r0, 6);

        // Toggling load_valid, then a five-cycle downstream stall.
        do_seq(8'b1011_0010, 8'd1, 1, 0, -1, -1, 1'b0);
        do_seq(8'b0110_1101, 8'd2, 0, 1, -1, -1, 1'b0);

        // Stray start during dump; abort during dump.
        d0 = done_cnt;
        do_seq(8'b1100_0101, 8'd1, 0, 0, -1, -1, 1'b1);
        check("single_done", done_cnt - d0, 1);
        do_seq(8'b1111_0000, 8'd2, 0, 0, -1, 4, 1'b0);

        // start and abort together in IDLE: stays idle.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);
        tick();

        // Asynchronous reset in the third RUN cycle.
        start = 1'b1; num_gens = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < CL; i++) begin
            load_valid = 1'b1; load_bit = 1'($urandom);
            tick();
        end
        load_valid = 1'b0;
        tick(); tick();
        check("in_run_cycle3", cell_run, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 10'd0);
        check("async_reset_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // Randomized sequences.
        for (int n = 0; n < 40; n++) begin
            int ab, al, ad;
            ab = $urandom_range(0, 9);
            al = (ab == 0) ? $urandom_range(0, CL - 1) : -1;
            ad = (ab == 1) ? $urandom_range(0, CL - 1) : -1;
            do_seq(8'($urandom), 8'($urandom_range(0, 4)), $urandom_range(0, 2),
                   $urandom_range(0, 2), al, ad, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
